// File: rtl/nvdla_reset_sequencer_if.sv
// Request handshake and partition reset outputs of nvdla_reset_sequencer.
// The requester holds the master modport; the sequencer holds the slave modport.
interface nvdla_reset_sequencer_if #(
    parameter int NUM_PART = 4
);
    logic                req_valid;
    logic                req_ready;
    logic [NUM_PART-1:0] req_mask;
    logic [7:0]          hold_cycles;
    logic [7:0]          gap_cycles;
    logic [NUM_PART-1:0] part_rstn;
    logic                busy;
    logic                done;

    modport master (
        output req_valid, req_mask, hold_cycles, gap_cycles,
        input  req_ready, part_rstn, busy, done
    );

    modport slave (
        input  req_valid, req_mask, hold_cycles, gap_cycles,
        output req_ready, part_rstn, busy, done
    );
endinterface

// File: rtl/nvdla_reset_sequencer.sv
// Partition reset sequencer: assert masked partitions, release them, settle, pulse done.
// Define NVDLA_RESET_SEQ_STAGGER_EN for one-partition-per-step release spaced by gap_cycles.
module nvdla_reset_sequencer #(
    parameter int NUM_PART   = 4,
    parameter int SETTLE_CYC = 3,
    parameter int POR_HOLD   = 16
) (
    input logic                    nvdla_clk,
    input logic                    nvdla_rst,
    nvdla_reset_sequencer_if.slave rs
);
    // Hold/gap counter is 8 bits unless POR_HOLD needs more room.
    localparam int CNT_W = (POR_HOLD > 255) ? $clog2(POR_HOLD + 1) : 8;
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] POR_CNT = CNT_W'((POR_HOLD < 1) ? 1 : POR_HOLD);
    localparam logic [SET_W-1:0] SET_CNT = SET_W'(SETTLE_CYC);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ASSERT  = 3'd1,
        RELEASE = 3'd2,
        SETTLE  = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t              state;
    logic [NUM_PART-1:0] pend;
    logic [NUM_PART-1:0] part_rstn;
    logic [CNT_W-1:0]    cnt;
    logic [SET_W-1:0]    settle_cnt;
    logic [7:0]          gap_q;
    logic                por;
    logic                req_ready;
    logic                busy;
    logic                done;

    logic [NUM_PART-1:0] rel_bits;
    logic [7:0]          hold_eff;
    logic [7:0]          gap_src;
    logic [7:0]          gap_eff;

`ifdef NVDLA_RESET_SEQ_STAGGER_EN
    // Lowest pending partition is released on each step.
    assign rel_bits = pend & (~pend + NUM_PART'(1));
`else
    assign rel_bits = pend;
`endif

    // Power-on has no accept cycle, so its gap is taken live until release begins.
    assign gap_src  = por ? rs.gap_cycles : gap_q;
    assign gap_eff  = (gap_src == 8'd0) ? 8'd1 : gap_src;
    assign hold_eff = (rs.hold_cycles == 8'd0) ? 8'd1 : rs.hold_cycles;

    always_ff @(posedge nvdla_clk or posedge nvdla_rst) begin
        if (nvdla_rst) begin
            state      <= ASSERT;
            por        <= 1'b1;
            pend       <= '1;
            part_rstn  <= '0;
            cnt        <= POR_CNT;
            settle_cnt <= SET_CNT;
            gap_q      <= 8'd0;
            req_ready  <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (rs.req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        gap_q     <= rs.gap_cycles;
                        por       <= 1'b0;
                        if (rs.req_mask != '0) begin
                            state     <= ASSERT;
                            pend      <= rs.req_mask;
                            part_rstn <= part_rstn & ~rs.req_mask;
                            cnt       <= CNT_W'(hold_eff);
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ASSERT: begin
                    if (cnt <= CNT_W'(1)) begin
                        state     <= RELEASE;
                        part_rstn <= part_rstn | rel_bits;
                        pend      <= pend & ~rel_bits;
                        cnt       <= CNT_W'(gap_eff);
                        gap_q     <= gap_src;
                        por       <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (pend == '0) begin
                        if (SETTLE_CYC == 0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= SETTLE;
                            settle_cnt <= SET_CNT;
                        end
                    end else if (cnt <= CNT_W'(1)) begin
                        part_rstn <= part_rstn | rel_bits;
                        pend      <= pend & ~rel_bits;
                        cnt       <= CNT_W'(gap_eff);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                SETTLE: begin
                    if (settle_cnt <= SET_W'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign rs.req_ready = req_ready;
    assign rs.part_rstn = part_rstn;
    assign rs.busy      = busy;
    assign rs.done      = done;
endmodule

// File: tb/tb_nvdla_reset_sequencer.sv
// Bench for nvdla_reset_sequencer: per-cycle timeline model plus directed literal checks.
module tb_nvdla_reset_sequencer;
    localparam int NP       = 4;
    localparam int SETTLE   = 3;
    localparam int POR_HOLD = 16;
`ifdef NVDLA_RESET_SEQ_STAGGER_EN
    localparam bit STAG = 1'b1;
`else
    localparam bit STAG = 1'b0;
`endif

    logic nvdla_clk = 1'b0;
    logic nvdla_rst = 1'b0;
    always #5 nvdla_clk = ~nvdla_clk;

    nvdla_reset_sequencer_if #(.NUM_PART(NP)) rs ();

    nvdla_reset_sequencer #(
        .NUM_PART(NP), .SETTLE_CYC(SETTLE), .POR_HOLD(POR_HOLD)
    ) dut (
        .nvdla_clk(nvdla_clk),
        .nvdla_rst(nvdla_rst),
        .rs(rs)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each sequence is a timeline in cycles d after its start (d=1 is the first cycle after accept).
    int              cyc = 0;
    bit              m_inrst = 1'b1;
    bit              m_ready = 1'b0;
    logic [NP-1:0]   m_rstn  = '0;
    int              t0 = 0;
    int              done_d = 0;
    logic [NP-1:0]   m_mask = '0;
    logic [NP-1:0]   m_base = '0;
    int              rel_d[NP];

    task automatic start_seq(input int t, input logic [NP-1:0] m, input int h, input int g,
                             input logic [NP-1:0] base);
        int hh, gg, j, last;
        hh = (h < 1) ? 1 : h;
        gg = (g < 1) ? 1 : g;
        j = 0;
        last = hh + 1;
        t0 = t;
        m_mask = m;
        m_base = base;
        for (int i = 0; i < NP; i++) begin
            rel_d[i] = hh + 1 + (STAG ? j * gg : 0);
            if (m[i]) begin
                last = rel_d[i];
                j++;
            end
        end
        done_d = (m == '0) ? 1 : last + SETTLE + 1;
    endtask

    always @(posedge nvdla_clk) begin
        logic [NP-1:0] er;
        logic eb, ed, ey;
        int d;
        cyc++;
        if (nvdla_rst) begin
            m_inrst = 1'b1;
            m_ready = 1'b0;
        end else if (m_inrst) begin
            m_inrst = 1'b0;
            start_seq(cyc - 1, '1, POR_HOLD, int'(rs.gap_cycles), '0);
        end else if (m_ready && rs.req_valid) begin
            start_seq(cyc, rs.req_mask, int'(rs.hold_cycles), int'(rs.gap_cycles), m_rstn);
        end
        #1;
        if (nvdla_rst) begin
            er = '0; eb = 1'b1; ed = 1'b0; ey = 1'b0;
        end else begin
            d  = cyc - t0 + 1;
            eb = (d <= done_d);
            ed = (d == done_d);
            ey = !eb;
            for (int i = 0; i < NP; i++)
                er[i] = m_mask[i] ? (d >= rel_d[i]) : m_base[i];
        end
        check("part_rstn", 32'(rs.part_rstn), 32'(er));
        check("busy", 32'(rs.busy), 32'(eb));
        check("done", 32'(rs.done), 32'(ed));
        check("req_ready", 32'(rs.req_ready), 32'(ey));
        m_ready = ey;
        m_rstn  = er;
    end

    task automatic wait_done(output int dd);
        dd = 1;
        while (!rs.done && dd < 3000) begin
            @(posedge nvdla_clk); #2;
            dd++;
        end
    endtask

    task automatic do_req(input logic [NP-1:0] m, input logic [7:0] h, input logic [7:0] g,
                          input bit keep, input int cap, output int dd,
                          output logic [NP-1:0] r1, output logic [NP-1:0] rc);
        int n;
        n = 0;
        while (!rs.req_ready && n < 3000) begin
            @(posedge nvdla_clk); #2;
            n++;
        end
        rs.req_valid = 1'b1;
        rs.req_mask = m; rs.hold_cycles = h; rs.gap_cycles = g;
        @(posedge nvdla_clk); #2;
        if (!keep) rs.req_valid = 1'b0;
        rs.req_mask    = NP'($urandom);
        rs.hold_cycles = 8'($urandom_range(0, 9));
        rs.gap_cycles  = 8'($urandom_range(0, 9));
        dd = 1;
        r1 = rs.part_rstn;
        rc = rs.part_rstn;
        while (!rs.done && dd < 3000) begin
            @(posedge nvdla_clk); #2;
            dd++;
            if (dd == cap) rc = rs.part_rstn;
        end
    endtask

    initial begin
        int dd;
        logic [NP-1:0] r1, rc;
        rs.req_valid = 1'b0; rs.req_mask = '0; rs.hold_cycles = 8'd0; rs.gap_cycles = 8'd2;
        #1 nvdla_rst = 1'b1;
        repeat (3) @(posedge nvdla_clk);
        #2 nvdla_rst = 1'b0;
        wait_done(dd);
        check("por_done_cycle", 32'(dd), STAG ? 32'd27 : 32'd21);

        do_req(4'b0101, 8'd4, 8'd3, 1'b0, 5, dd, r1, rc);
        check("m0101_done_cycle", 32'(dd), STAG ? 32'd12 : 32'd9);
        check("m0101_assert", 32'(r1), 32'b1010);
        check("m0101_first_rel", 32'(rc), STAG ? 32'b1011 : 32'b1111);

        do_req(4'b1111, 8'd2, 8'd5, 1'b0, 3, dd, r1, rc);
        check("m1111_rel", 32'(rc), STAG ? 32'b0001 : 32'b1111);
        check("m1111_done_cycle", 32'(dd), STAG ? 32'd22 : 32'd7);

        do_req(4'b0001, 8'd0, 8'd0, 1'b0, 2, dd, r1, rc);
        check("hold0_done_cycle", 32'(dd), 32'd6);
        check("hold0_rel", 32'(rc), 32'b1111);

        do_req(4'b0000, 8'd7, 8'd7, 1'b1, 1, dd, r1, rc);
        check("mask0_done_cycle", 32'(dd), 32'd1);
        check("mask0_untouched", 32'(r1), 32'b1111);
        @(posedge nvdla_clk); #2;
        check("held_valid_idle_ready", 32'(rs.req_ready), 32'd1);
        @(posedge nvdla_clk); #2;
        check("held_valid_accepted", 32'(rs.busy), 32'd1);
        rs.req_valid = 1'b0;

        // Reset pulse while partitions are being released.
        dd = 0;
        while (!rs.req_ready && dd < 3000) begin
            @(posedge nvdla_clk); #2;
            dd++;
        end
        rs.req_valid = 1'b1; rs.req_mask = 4'b1111; rs.hold_cycles = 8'd2; rs.gap_cycles = 8'd4;
        @(posedge nvdla_clk); #2;
        rs.req_valid = 1'b0;
        rs.gap_cycles = 8'd2;
        repeat (2) begin @(posedge nvdla_clk); #2; end
        #1 nvdla_rst = 1'b1;
        #1;
        check("midrst_async_rstn", 32'(rs.part_rstn), 32'd0);
        check("midrst_busy", 32'(rs.busy), 32'd1);
        @(posedge nvdla_clk); #2;
        nvdla_rst = 1'b0;
        wait_done(dd);
        check("midrst_por_done_cycle", 32'(dd), STAG ? 32'd27 : 32'd21);

        repeat (800) begin
            @(posedge nvdla_clk); #2;
            rs.req_valid   = ($urandom_range(0, 2) == 0);
            rs.req_mask    = NP'($urandom);
            rs.hold_cycles = ($urandom_range(0, 19) == 0) ? 8'd255 : 8'($urandom_range(0, 6));
            rs.gap_cycles  = 8'($urandom_range(0, 4));
        end
        rs.req_valid = 1'b0;
        dd = 0;
        while (!rs.req_ready && dd < 3000) begin
            @(posedge nvdla_clk); #2;
            dd++;
        end
        check("final_idle", 32'(rs.req_ready), 32'd1);
        repeat (3) @(posedge nvdla_clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
